// File: rtl/jtsdram_seq_pkg.sv
// Shared types and constants for the SDRAM test sequencer: FSM states,
// fixed per-pass reference patterns and the LFSR seed/taps.
package jtsdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_END    = 3'd5
    } state_t;

    localparam logic [15:0] PAT_P0     = 16'h0000;
    localparam logic [15:0] PAT_P1     = 16'hFFFF;
    localparam logic [15:0] PAT_P2     = 16'h5555;
    localparam logic [15:0] PAT_P3     = 16'hAAAA;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;

    function automatic logic [15:0] fixed_pat(input logic [1:0] idx);
        case (idx)
            2'd0:    fixed_pat = PAT_P0;
            2'd1:    fixed_pat = PAT_P1;
            2'd2:    fixed_pat = PAT_P2;
            default: fixed_pat = PAT_P3;
        endcase
    endfunction

endpackage

// File: rtl/jtsdram_seq_if.sv
// Bus between the sequencer (master) and the array of bank checkers (slave).
interface jtsdram_seq_if #(
    parameter int BANKS = 4
);
    logic             bank_start;
    logic [15:0]      data_ref;
    logic [BANKS-1:0] bank_done;
    logic [BANKS-1:0] bank_bad;

    modport master (output bank_start, output data_ref, input bank_done, input bank_bad);
    modport slave  (input bank_start, input data_ref, output bank_done, output bank_bad);
endinterface

// File: rtl/jtsdram_seq_lfsr.sv
// 16-bit Fibonacci LFSR supplying pseudo-random reference words; o_nxt
// exposes the value after one shift so the caller can register it directly.
module jtsdram_lfsr16
    import jtsdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    input  logic        i_load,
    output logic [15:0] o_q,
    output logic [15:0] o_nxt
);
    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb  = ^(r_q & LFSR_TAPS);
    assign o_nxt = {w_fb, r_q[15:1]};
    assign o_q   = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= LFSR_SEED;
        else if (i_load)
            r_q <= LFSR_SEED;
        else if (i_adv)
            r_q <= o_nxt;
    end
endmodule

// File: rtl/jtsdram_seq.sv
// SDRAM test sequencer: runs read-verify passes over the bank checkers,
// picking a pattern per pass and merging bad flags into sticky results.
module jtsdram_seq
    import jtsdram_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int PASSW = 8,
    parameter int TOUTW = 24
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              run,
    input  logic [PASSW-1:0]  npass,
    input  logic              stop_bad,
    jtsdram_seq_if.master     bus,
    output logic              busy,
    output logic              finished,
    output logic              timeout,
    output logic [BANKS-1:0]  bad_mask,
    output logic [PASSW-1:0]  pass_cnt
);
    state_t           r_state, w_next;
    logic             r_run_d;
    logic [TOUTW-1:0] r_wdog;
    logic [15:0]      r_data_ref;
    logic             w_rise, w_start, w_check, w_last, w_all_done, w_wdog_full;
    logic             w_start_pls, w_lfsr_adv;
    logic [PASSW-1:0] w_pass_nx;
    logic [15:0]      w_lfsr_q, w_lfsr_nxt, w_next_ref;

    assign w_rise      = run & ~r_run_d;
    assign w_start     = (r_state == ST_IDLE) && w_rise;
    assign w_check     = (r_state == ST_CHECK) && run;
    assign w_all_done  = &bus.bank_done;
    assign w_wdog_full = &r_wdog;
    assign w_pass_nx   = pass_cnt + PASSW'(1);
    assign w_last      = ((npass != '0) && (w_pass_nx == npass)) || (stop_bad && (|bus.bank_bad));
    assign w_lfsr_adv  = w_check && (pass_cnt > PASSW'(3));

    // Passes 4 and up take the LFSR word; once already in that range the
    // register shifts this cycle, so the following word is its next value.
    always_comb begin
        w_next_ref = fixed_pat(w_pass_nx[1:0]);
        if (w_pass_nx > PASSW'(3))
            w_next_ref = (pass_cnt > PASSW'(3)) ? w_lfsr_nxt : w_lfsr_q;
    end

    jtsdram_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (w_lfsr_adv),
        .i_load (w_start),
        .o_q    (w_lfsr_q),
        .o_nxt  (w_lfsr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_rise) w_next = ST_START;
            ST_START:  w_next = run ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: w_next = run ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (!run)             w_next = ST_IDLE;
                else if (w_all_done)  w_next = ST_CHECK;
                else if (w_wdog_full) w_next = ST_END;
            end
            ST_CHECK:  w_next = !run ? ST_IDLE : (w_last ? ST_END : ST_START);
            ST_END:    if (!run) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start_pls = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_START: begin
                w_start_pls = run;
                busy        = 1'b1;
            end
            ST_SETTLE, ST_WAIT, ST_CHECK: busy = 1'b1;
            default: ;
        endcase
    end

    assign bus.bank_start = w_start_pls;
    assign bus.data_ref   = r_data_ref;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_d    <= 1'b0;
            r_wdog     <= '0;
            r_data_ref <= PAT_P0;
            finished   <= 1'b0;
            timeout    <= 1'b0;
            bad_mask   <= '0;
            pass_cnt   <= '0;
        end else begin
            r_run_d <= run;
            if (w_start) begin
                r_data_ref <= PAT_P0;
                finished   <= 1'b0;
                timeout    <= 1'b0;
                bad_mask   <= '0;
                pass_cnt   <= '0;
            end
            if (r_state == ST_SETTLE)
                r_wdog <= '0;
            else if (r_state == ST_WAIT)
                r_wdog <= r_wdog + TOUTW'(1);
            // Completion on the same cycle as watchdog expiry counts as done.
            if ((r_state == ST_WAIT) && run && !w_all_done && w_wdog_full)
                timeout <= 1'b1;
            if (w_check) begin
                bad_mask   <= bad_mask | bus.bank_bad;
                pass_cnt   <= w_pass_nx;
                r_data_ref <= w_next_ref;
                if (w_last)
                    finished <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtsdram_seq.sv
// Directed bench for jtsdram_seq with behavioural bank checker models.
module tb_jtsdram_seq;
    localparam int BANKS = 4;
    localparam int PASSW = 3;
    localparam int TOUTW = 6;
    localparam int DLY   = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             stop_bad = 1'b0;
    logic [PASSW-1:0] npass = '0;
    logic             busy, finished, timeout;
    logic [BANKS-1:0] bad_mask;
    logic [PASSW-1:0] pass_cnt;

    int n_chk = 0;
    int n_err = 0;

    jtsdram_seq_if #(.BANKS(BANKS)) bus ();

    jtsdram_seq #(.BANKS(BANKS), .PASSW(PASSW), .TOUTW(TOUTW)) dut (
        .rst      (rst),
        .clk      (clk),
        .run      (run),
        .npass    (npass),
        .stop_bad (stop_bad),
        .bus      (bus.master),
        .busy     (busy),
        .finished (finished),
        .timeout  (timeout),
        .bad_mask (bad_mask),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: cumulative start count, data_ref/pass_cnt at each start, busy cycles
    int          tb_starts = 0;
    int          busy_cyc  = 0;
    logic [15:0] refs [64];
    logic [7:0]  pcs  [64];

    always @(negedge clk) begin
        if (bus.bank_start) begin
            if (tb_starts < 64) begin
                refs[tb_starts] = bus.data_ref;
                pcs[tb_starts]  = 8'(pass_cnt);
            end
            tb_starts = tb_starts + 1;
        end
        if (busy)
            busy_cyc = busy_cyc + 1;
    end

    // Checker models: done DLY cycles after start; bad on a chosen absolute start index
    int   cnt     [BANKS];
    int   bad_at  [BANKS];
    logic never   [BANKS];

    always @(posedge clk) begin
        if (rst) begin
            bus.bank_done <= '0;
            bus.bank_bad  <= '0;
            for (int b = 0; b < BANKS; b++) cnt[b] <= 0;
        end else if (bus.bank_start) begin
            bus.bank_done <= '0;
            bus.bank_bad  <= '0;
            for (int b = 0; b < BANKS; b++) cnt[b] <= DLY;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (cnt[b] > 0) begin
                    cnt[b] <= cnt[b] - 1;
                    if (cnt[b] == 1 && !never[b]) begin
                        bus.bank_done[b] <= 1'b1;
                        bus.bank_bad[b]  <= (bad_at[b] == tb_starts - 1);
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        check_val({tag, "_ended"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int k = 0;
        while (tb_starts < target && k < budget) begin
            step(1);
            k++;
        end
        check_val({tag, "_starts_reached"}, 32'(tb_starts >= target), 32'd1);
    endtask

    logic [15:0] exp_ref [9] = '{16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA,
                                 16'hACE1, 16'h5670, 16'hAB38, 16'h559C, 16'h0000};

    initial begin
        int base, bbase;
        for (int b = 0; b < BANKS; b++) begin
            bad_at[b] = -1;
            never[b]  = 1'b0;
        end

        step(3);
        check_val("rst_busy",     32'(busy),           32'd0);
        check_val("rst_finished", 32'(finished),       32'd0);
        check_val("rst_timeout",  32'(timeout),        32'd0);
        check_val("rst_badmask",  32'(bad_mask),       32'd0);
        check_val("rst_passcnt",  32'(pass_cnt),       32'd0);
        check_val("rst_start",    32'(bus.bank_start), 32'd0);
        check_val("rst_dataref",  32'(bus.data_ref),   32'd0);
        rst = 1'b0;
        step(3);
        check_val("idle_start", 32'(tb_starts), 32'd0);

        // Two clean passes
        base  = tb_starts;
        npass = 3'd2;
        run   = 1'b1;
        step(1);
        check_val("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1", 2000);
        check_val("t1_starts",   32'(tb_starts - base), 32'd2);
        check_val("t1_ref0",     32'(refs[base]),       32'h0000);
        check_val("t1_ref1",     32'(refs[base+1]),     32'hFFFF);
        check_val("t1_finished", 32'(finished),         32'd1);
        check_val("t1_passcnt",  32'(pass_cnt),         32'd2);
        check_val("t1_badmask",  32'(bad_mask),         32'd0);
        check_val("t1_timeout",  32'(timeout),          32'd0);
        run = 1'b0;
        step(2);

        // Bank 2 bad in pass 1, keep going
        base      = tb_starts;
        bad_at[2] = base + 1;
        npass     = 3'd3;
        run       = 1'b1;
        step(1);
        wait_idle("t2", 3000);
        check_val("t2_starts",   32'(tb_starts - base), 32'd3);
        check_val("t2_ref2",     32'(refs[base+2]),     32'h5555);
        check_val("t2_badmask",  32'(bad_mask),         32'b0100);
        check_val("t2_passcnt",  32'(pass_cnt),         32'd3);
        check_val("t2_finished", 32'(finished),         32'd1);
        run = 1'b0;
        step(2);

        // Same with stop_bad
        base      = tb_starts;
        bad_at[2] = base + 1;
        stop_bad  = 1'b1;
        run       = 1'b1;
        step(1);
        wait_idle("t3", 3000);
        step(60);
        check_val("t3_starts",   32'(tb_starts - base), 32'd2);
        check_val("t3_passcnt",  32'(pass_cnt),         32'd2);
        check_val("t3_finished", 32'(finished),         32'd1);
        check_val("t3_badmask",  32'(bad_mask),         32'b0100);
        run       = 1'b0;
        stop_bad  = 1'b0;
        bad_at[2] = -1;
        step(2);

        // Bank 3 never done: watchdog (START + SETTLE + 64 WAIT cycles busy)
        base     = tb_starts;
        bbase    = busy_cyc;
        never[3] = 1'b1;
        npass    = 3'd2;
        run      = 1'b1;
        step(1);
        wait_idle("t4", 500);
        check_val("t4_timeout",  32'(timeout),            32'd1);
        check_val("t4_finished", 32'(finished),           32'd0);
        check_val("t4_busycyc",  32'(busy_cyc - bbase),   32'd66);
        check_val("t4_starts",   32'(tb_starts - base),   32'd1);
        check_val("t4_passcnt",  32'(pass_cnt),           32'd0);
        never[3] = 1'b0;
        run      = 1'b0;
        step(2);

        // Abort mid-WAIT of pass 1, then rerun
        base  = tb_starts;
        npass = 3'd3;
        run   = 1'b1;
        step(1);
        check_val("t5_timeout_cleared", 32'(timeout), 32'd0);
        wait_starts("t5", base + 2, 300);
        step(10);
        check_val("t5_busy_wait", 32'(busy), 32'd1);
        run = 1'b0;
        step(1);
        check_val("t5_abort_busy",     32'(busy),     32'd0);
        check_val("t5_abort_finished", 32'(finished), 32'd0);
        check_val("t5_abort_passcnt",  32'(pass_cnt), 32'd1);
        step(100);
        check_val("t5_no_more_starts", 32'(tb_starts - base), 32'd2);
        base  = tb_starts;
        npass = 3'd1;
        run   = 1'b1;
        step(1);
        check_val("t5_rerun_passcnt", 32'(pass_cnt), 32'd0);
        wait_idle("t5r", 1000);
        check_val("t5_rerun_finished", 32'(finished),         32'd1);
        check_val("t5_rerun_passcnt1", 32'(pass_cnt),         32'd1);
        check_val("t5_rerun_starts",   32'(tb_starts - base), 32'd1);
        check_val("t5_rerun_ref0",     32'(refs[base]),       32'h0000);
        run = 1'b0;
        step(2);

        // Endless test: pattern table, LFSR words and pass counter wrap
        base  = tb_starts;
        npass = 3'd0;
        run   = 1'b1;
        step(1);
        wait_starts("t6", base + 9, 2000);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("t6_ref%0d", i), 32'(refs[base+i]), 32'(exp_ref[i]));
        check_val("t6_pc_before_wrap", 32'(pcs[base+7]), 32'd7);
        check_val("t6_pc_wrapped",     32'(pcs[base+8]), 32'd0);
        check_val("t6_finished",       32'(finished),    32'd0);
        run = 1'b0;
        step(2);
        check_val("t6_stop_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
